// File: rtl/iir_biquad_sequencer_pkg.sv
// Shared constants, types and helpers for the biquad sequencer.
package iir_biquad_sequencer_pkg;

  localparam int unsigned W     = 24;
  localparam int unsigned ACC_W = 27;
  localparam int unsigned CNT_W = 3;

  localparam logic signed [W-1:0] Q22_MAX = 24'sh7FFFFF;
  localparam logic signed [W-1:0] Q22_MIN = 24'sh800000;

  // Saturation bounds widened to accumulator width
  localparam logic signed [ACC_W-1:0] ACC_HI = {{(ACC_W-W){1'b0}}, Q22_MAX};
  localparam logic signed [ACC_W-1:0] ACC_LO = {{(ACC_W-W){1'b1}}, Q22_MIN};

  // Tap order: feed-forward terms first, then the subtracted feedback terms
  localparam logic [CNT_W-1:0] TAP_B0 = 3'd0;
  localparam logic [CNT_W-1:0] TAP_B1 = 3'd1;
  localparam logic [CNT_W-1:0] TAP_B2 = 3'd2;
  localparam logic [CNT_W-1:0] TAP_A1 = 3'd3;
  localparam logic [CNT_W-1:0] TAP_A2 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_OUT     = 2'd3
  } state_t;

  typedef struct packed {
    logic [W-1:0] b0;
    logic [W-1:0] b1;
    logic [W-1:0] b2;
    logic [W-1:0] a1;
    logic [W-1:0] a2;
  } coef_t;

  // x0 is the sample being processed; the rest is filter history
  typedef struct packed {
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
  } hist_t;

  // Clamp an accumulator value into the Q2.22 range
  function automatic logic [W-1:0] sat_q22(input logic signed [ACC_W-1:0] acc);
    logic [W-1:0] r;
    if (acc > ACC_HI)      r = Q22_MAX;
    else if (acc < ACC_LO) r = Q22_MIN;
    else                   r = acc[W-1:0];
    return r;
  endfunction

  // Data operand for a given tap
  function automatic logic [W-1:0] tap_data(input logic [CNT_W-1:0] tap, input hist_t h);
    logic [W-1:0] d;
    case (tap)
      TAP_B0:  d = h.x0;
      TAP_B1:  d = h.x1;
      TAP_B2:  d = h.x2;
      TAP_A1:  d = h.y1;
      default: d = h.y2;
    endcase
    return d;
  endfunction

  // Coefficient operand for a given tap
  function automatic logic [W-1:0] tap_coef(input logic [CNT_W-1:0] tap, input coef_t c);
    logic [W-1:0] d;
    case (tap)
      TAP_B0:  d = c.b0;
      TAP_B1:  d = c.b1;
      TAP_B2:  d = c.b2;
      TAP_A1:  d = c.a1;
      default: d = c.a2;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/iir_biquad_sequencer_q22_sat_acc.sv
// Wide accumulator with add/subtract select and a saturated Q2.22 view.
module q22_sat_acc
  import iir_biquad_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         sub,
  input  logic [W-1:0] din,
  output logic [W-1:0] sat_c
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] din_ext;

  // Next accumulator value; clear wins over accumulate
  always_comb begin
    din_ext = {{(ACC_W-W){din[W-1]}}, din};
    acc_d   = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = sub ? (acc_q - din_ext) : (acc_q + din_ext);
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign sat_c = sat_q22(acc_q);

endmodule

// File: rtl/iir_biquad_sequencer.sv
// Direct-Form-I biquad sequencer sharing one external pipelined multiplier.
module iir_biquad_sequencer
  import iir_biquad_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x_in,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [W-1:0] coef_b0,
  input  logic [W-1:0] coef_b1,
  input  logic [W-1:0] coef_b2,
  input  logic [W-1:0] coef_a1,
  input  logic [W-1:0] coef_a2,
  input  logic         clear,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  output logic         mul_valid,
  input  logic [W-1:0] mul_p,
  input  logic         mul_pvalid,
  output logic [W-1:0] y_out,
  output logic         y_valid
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  hist_t            hist_q, hist_d;
  coef_t            coef_q, coef_d;
  logic             rdy_q, rdy_d;
  logic [W-1:0]     mul_a_d, mul_b_d, y_out_d;
  logic             mul_valid_d, y_valid_d;
  logic             accept, take;
  logic             acc_clr, acc_en, acc_sub;
  logic [W-1:0]     acc_sat_c;

  // Ready is registered but dropped immediately while clear is asserted
  assign x_ready = rdy_q & ~clear;

  q22_sat_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .sub   (acc_sub),
    .din   (mul_p),
    .sat_c (acc_sat_c)
  );

  // Next-state, operand issue, product collection and history update
  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    ret_d       = ret_q;
    hist_d      = hist_q;
    coef_d      = coef_q;
    mul_a_d     = '0;
    mul_b_d     = '0;
    mul_valid_d = 1'b0;
    y_out_d     = y_out;
    y_valid_d   = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    acc_sub     = 1'b0;
    accept      = x_valid && x_ready;
    take        = mul_pvalid && (outst_q != '0);
    outst_d     = outst_q + CNT_W'(mul_valid) - CNT_W'(take);

    if (clear) begin
      // In-flight products still drain through outst_d but never reach acc
      state_d   = ST_IDLE;
      issue_d   = '0;
      ret_d     = '0;
      hist_d.x1 = '0;
      hist_d.x2 = '0;
      hist_d.y1 = '0;
      hist_d.y2 = '0;
      acc_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            hist_d.x0   = x_in;
            coef_d      = '{b0: coef_b0, b1: coef_b1, b2: coef_b2, a1: coef_a1, a2: coef_a2};
            issue_d     = TAP_B0;
            ret_d       = '0;
            mul_valid_d = 1'b1;
            mul_a_d     = x_in;
            mul_b_d     = coef_b0;
            state_d     = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue_q == TAP_A2) begin
            state_d = ST_COLLECT;
          end else begin
            issue_d     = issue_q + CNT_W'(1);
            mul_valid_d = 1'b1;
            mul_a_d     = tap_data(issue_d, hist_q);
            mul_b_d     = tap_coef(issue_d, coef_q);
          end
        end
        ST_OUT: begin
          y_out_d   = acc_sat_c;
          y_valid_d = 1'b1;
          hist_d.x2 = hist_q.x1;
          hist_d.x1 = hist_q.x0;
          hist_d.y2 = hist_q.y1;
          hist_d.y1 = acc_sat_c;
          acc_clr   = 1'b1;
          issue_d   = '0;
          state_d   = ST_IDLE;
        end
        default: begin
        end
      endcase

      // Products return in issue order; collection may overlap issue
      if (((state_q == ST_ISSUE) || (state_q == ST_COLLECT)) && take) begin
        acc_en  = 1'b1;
        acc_sub = (ret_q >= TAP_A1);
        if (ret_q == TAP_A2) begin
          ret_d   = '0;
          state_d = ST_OUT;
        end else begin
          ret_d = ret_q + CNT_W'(1);
        end
      end
    end

    // Ready only after a full idle cycle with the multiplier drained
    rdy_d = (state_q == ST_IDLE) && (state_d == ST_IDLE) && (outst_d == '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      issue_q   <= '0;
      ret_q     <= '0;
      outst_q   <= '0;
      hist_q    <= '0;
      coef_q    <= '0;
      rdy_q     <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_valid <= 1'b0;
      y_out     <= '0;
      y_valid   <= 1'b0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      ret_q     <= ret_d;
      outst_q   <= outst_d;
      hist_q    <= hist_d;
      coef_q    <= coef_d;
      rdy_q     <= rdy_d;
      mul_a     <= mul_a_d;
      mul_b     <= mul_b_d;
      mul_valid <= mul_valid_d;
      y_out     <= y_out_d;
      y_valid   <= y_valid_d;
    end
  end

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Directed bench for iir_biquad_sequencer with a variable-latency Q2.22 multiplier model.
module tb_iir_biquad_sequencer;

  localparam int W = 24;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] x_in;
  logic         x_valid;
  logic         x_ready;
  logic [W-1:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
  logic         clear;
  logic [W-1:0] mul_a, mul_b;
  logic         mul_valid;
  logic [W-1:0] mul_p;
  logic         mul_pvalid;
  logic [W-1:0] y_out;
  logic         y_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 1;

  iir_biquad_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_in       (x_in),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .coef_b0    (coef_b0),
    .coef_b1    (coef_b1),
    .coef_b2    (coef_b2),
    .coef_a1    (coef_a1),
    .coef_a2    (coef_a2),
    .clear      (clear),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_valid  (mul_valid),
    .mul_p      (mul_p),
    .mul_pvalid (mul_pvalid),
    .y_out      (y_out),
    .y_valid    (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipelined Q2.22 multiplier, latency selectable 1..4 (changed only when empty)
  logic signed [47:0] prod;
  logic [3:0]         pv;
  logic [W-1:0]       pp [4];
  assign prod = $signed(mul_a) * $signed(mul_b);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < 4; i++) pp[i] <= '0;
    end else begin
      pv    <= {pv[2:0], mul_valid};
      pp[0] <= W'(prod >>> 22);
      for (int i = 1; i < 4; i++) pp[i] <= pp[i-1];
    end
  end
  assign mul_pvalid = pv[lat-1];
  assign mul_p      = pp[lat-1];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_coefs(input logic [W-1:0] b0, input logic [W-1:0] b1, input logic [W-1:0] b2,
                           input logic [W-1:0] a1, input logic [W-1:0] a2);
    coef_b0 = b0; coef_b1 = b1; coef_b2 = b2; coef_a1 = a1; coef_a2 = a2;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (x_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready_wait"}, 32'(x_ready), 32'd1);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_ready(tag);
  endtask

  // One sample: accept, measure latency, check output and ready recovery
  task automatic run_sample(input string tag, input logic [W-1:0] x, input logic [W-1:0] exp_y);
    int n = 0;
    wait_ready(tag);
    x_in    = x;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    x_in    = '0;
    check({tag, "_ready_low"}, 32'(x_ready), 32'd0);
    while (y_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(6 + lat));
    check({tag, "_y"}, 32'(y_out), 32'(exp_y));
    check({tag, "_ready_at_yvalid"}, 32'(x_ready), 32'd0);
    tick();
    check({tag, "_yvalid_pulse"}, 32'(y_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(x_ready), 32'd1);
  endtask

  initial begin
    int acc_n, yv_n, ovl_n, n;
    logic seen_y, seen_mv;

    rst_n = 1'b0; x_in = '0; x_valid = 1'b0; clear = 1'b0;
    set_coefs('0, '0, '0, '0, '0);
    #2;
    check("rst_ready", 32'(x_ready), 32'd0);
    repeat (3) tick();
    check("rst_mul_valid", 32'(mul_valid), 32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y_out", 32'(y_out), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    rst_n = 1'b1;
    check("rst_ready_release", 32'(x_ready), 32'd0);
    tick();
    check("rst_ready_first", 32'(x_ready), 32'd1);

    // Pass-through, L=1 and L=3
    set_coefs(24'h400000, '0, '0, '0, '0);
    run_sample("pass_l1", 24'h100000, 24'h100000);
    do_clear("pass_clr");
    lat = 3;
    run_sample("pass_l3", 24'h100000, 24'h100000);
    lat = 1;

    // FIR averaging of a step
    do_clear("fir_clr");
    set_coefs(24'h200000, 24'h200000, 24'h200000, '0, '0);
    run_sample("fir_0", 24'h100000, 24'h080000);
    run_sample("fir_1", 24'h100000, 24'h100000);
    run_sample("fir_2", 24'h100000, 24'h180000);

    // Feedback decay: y = x + 0.5*y1
    do_clear("fb_clr");
    set_coefs(24'h400000, '0, '0, 24'hE00000, '0);
    run_sample("fb_0", 24'h100000, 24'h100000);
    run_sample("fb_1", 24'h000000, 24'h080000);
    run_sample("fb_2", 24'h000000, 24'h040000);

    // Saturation, both directions
    do_clear("sat_clr");
    set_coefs(24'h400000, 24'h400000, 24'h400000, '0, '0);
    run_sample("satp_0", 24'h600000, 24'h600000);
    run_sample("satp_1", 24'h600000, 24'h7FFFFF);
    run_sample("satp_2", 24'h600000, 24'h7FFFFF);
    do_clear("satn_clr");
    run_sample("satn_0", 24'hA00000, 24'hA00000);
    run_sample("satn_1", 24'hA00000, 24'h800000);
    run_sample("satn_2", 24'hA00000, 24'h800000);

    // Clear two cycles after the last issue with products still in flight (L=4)
    lat = 4;
    wait_ready("cm");
    x_in = 24'h100000; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    check("cm_issue_first", 32'(mul_valid), 32'd1);
    repeat (4) tick();
    check("cm_issue_last", 32'(mul_valid), 32'd1);
    tick();
    check("cm_issue_done", 32'(mul_valid), 32'd0);
    tick();
    clear = 1'b1;
    check("cm_ready_in_clear", 32'(x_ready), 32'd0);
    tick();
    clear = 1'b0;
    n = 0; seen_y = 1'b0; seen_mv = 1'b0;
    while (x_ready !== 1'b1 && n < 30) begin
      if (y_valid === 1'b1) seen_y = 1'b1;
      if (mul_valid === 1'b1) seen_mv = 1'b1;
      tick();
      n++;
    end
    check("cm_ready_drain", 32'(n), 32'd2);
    check("cm_no_yvalid", 32'(seen_y), 32'd0);
    check("cm_no_mulvalid", 32'(seen_mv), 32'd0);
    lat = 1;
    // History taps weighted so any residue from before the clear would show
    set_coefs(24'h400000, 24'h400000, 24'h400000, 24'hE00000, 24'h400000);
    run_sample("cm_after", 24'h100000, 24'h100000);

    // x_valid held high: one accept per sequence, ready never with y_valid
    set_coefs(24'h400000, '0, '0, '0, '0);
    wait_ready("hs");
    x_in = 24'h100000; x_valid = 1'b1;
    acc_n = 0; yv_n = 0; ovl_n = 0;
    for (int s = 0; s < 27; s++) begin
      if (x_ready === 1'b1) acc_n++;
      if (y_valid === 1'b1) begin
        yv_n++;
        check("hs_y", 32'(y_out), 32'h100000);
      end
      if (x_ready === 1'b1 && y_valid === 1'b1) ovl_n++;
      tick();
    end
    check("hs_accepts", 32'(acc_n), 32'd3);
    check("hs_outputs", 32'(yv_n), 32'd3);
    check("hs_overlap", 32'(ovl_n), 32'd0);

    // Reset in the middle of ISSUE
    check("mr_ready_next", 32'(x_ready), 32'd1);
    tick();
    tick();
    x_valid = 1'b0;
    check("mr_in_issue", 32'(mul_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_mul_valid", 32'(mul_valid), 32'd0);
    check("mr_mul_a", 32'(mul_a), 32'd0);
    check("mr_mul_b", 32'(mul_b), 32'd0);
    check("mr_y_out", 32'(y_out), 32'd0);
    check("mr_y_valid", 32'(y_valid), 32'd0);
    check("mr_ready", 32'(x_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_ready_release", 32'(x_ready), 32'd1);
    set_coefs(24'h400000, 24'h400000, '0, '0, '0);
    run_sample("mr_after", 24'h100000, 24'h100000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
